// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
// Widths, register count, FSM states and requester IDs.
package regfile_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = $clog2(NUM_REGS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the last winner loses the next tie.
// last_grant only moves when a grant is actually taken.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    input  logic accept,
    output logic gnt_a,
    output logic gnt_b
);

    req_id_e last_q;
    req_id_e last_d;

    // Grant: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (enable) begin
            unique case (1'b1)
                (req_a && !req_b): gnt_a = 1'b1;
                (!req_a && req_b): gnt_b = 1'b1;
                (req_a && req_b): begin
                    gnt_a = (last_q == REQ_B);
                    gnt_b = (last_q == REQ_A);
                end
                default: ;
            endcase
        end
    end

    // Record the winner whenever a handshake completes
    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = gnt_b ? REQ_B : REQ_A;
        end
    end

    // Priority register; resets to B so A wins the first tie
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU (A) and load (B) writeback onto the single RF write port.
// After reset it first fills register[i] = i for every entry.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W           = DEF_ADDR_W,
    parameter int DATA_W           = DEF_DATA_W,
    parameter int INIT_ON_RESET    = 1,
    parameter int ZERO_REG_PROTECT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a_valid,
    input  logic [ADDR_W-1:0] req_a_address,
    input  logic [DATA_W-1:0] req_a_data,
    output logic              req_a_ready,
    input  logic              req_b_valid,
    input  logic [ADDR_W-1:0] req_b_address,
    input  logic [DATA_W-1:0] req_b_data,
    output logic              req_b_ready,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_WriteEnable,
    output logic              init_done
);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              we_q;
    logic              we_d;
    logic              init_done_q;
    logic              init_done_d;

    logic              gnt_a;
    logic              gnt_b;
    logic              accept;
    logic              last_cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (init_done_q),
        .req_a  (req_a_valid),
        .req_b  (req_b_valid),
        .accept (accept),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    assign req_a_ready = gnt_a;
    assign req_b_ready = gnt_b;
    assign accept      = gnt_a | gnt_b;
    assign last_cnt    = (cnt_q == CNT_W'(NUM_REGS - 1));
    assign sel_addr    = gnt_b ? req_b_address : req_a_address;
    assign sel_data    = gnt_b ? req_b_data : req_a_data;

    // State register; reset lands in init or skips straight to run
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave init once the last register has been issued
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: if (last_cnt) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
        endcase
    end

    // Next values for the write port, init counter and done flag
    always_comb begin
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = 1'b0;
        init_done_d = init_done_q;
        unique case (state_q)
            ST_INIT: begin
                addr_d = ADDR_W'(cnt_q);
                data_d = DATA_W'(cnt_q);
                we_d   = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            ST_RUN: begin
                init_done_d = 1'b1;
                if (accept) begin
                    addr_d = sel_addr;
                    data_d = sel_data;
                    we_d   = !((ZERO_REG_PROTECT != 0) &&
                               (sel_addr == '0));
                end
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            init_done_q <= init_done_d;
        end
    end

    assign rf_write_address = addr_q;
    assign rf_write_data    = data_q;
    assign rf_WriteEnable   = we_q;
    assign init_done        = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised bench for regfile_write_arbiter with an inline
// behavioural model of the write port and the round-robin rule.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_a_valid = 1'b0;
    logic [4:0]  req_a_address = '0;
    logic [31:0] req_a_data = '0;
    logic        req_a_ready;
    logic        req_b_valid = 1'b0;
    logic [4:0]  req_b_address = '0;
    logic [31:0] req_b_data = '0;
    logic        req_b_ready;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;
    logic        rf_WriteEnable;
    logic        init_done;

    always #5 clock = ~clock;

    regfile_write_arbiter #(
        .ADDR_W           (5),
        .DATA_W           (32),
        .INIT_ON_RESET    (1),
        .ZERO_REG_PROTECT (1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_a_valid      (req_a_valid),
        .req_a_address    (req_a_address),
        .req_a_data       (req_a_data),
        .req_a_ready      (req_a_ready),
        .req_b_valid      (req_b_valid),
        .req_b_address    (req_b_address),
        .req_b_data       (req_b_data),
        .req_b_ready      (req_b_ready),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .rf_WriteEnable   (rf_WriteEnable),
        .init_done        (init_done)
    );

    int checks = 0;
    int errors = 0;

    // pending requester transactions
    bit          pa_v, pb_v;
    logic [4:0]  pa_addr, pb_addr;
    logic [31:0] pa_data, pb_data;
    bit          rand_mode = 0;

    // model: edges since reset release, last winner, expected port
    int          e;
    bit          m_last;
    logic [4:0]  ea;
    logic [31:0] ed;
    bit          ewe;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic apply();
        req_a_valid   = pa_v;
        req_a_address = pa_addr;
        req_a_data    = pa_data;
        req_b_valid   = pb_v;
        req_b_address = pb_addr;
        req_b_data    = pb_data;
    endtask

    task automatic model_reset();
        e = 0;
        m_last = 1;
        ea = '0;
        ed = '0;
        ewe = 0;
    endtask

    task automatic new_req(output logic [4:0] a, output logic [31:0] d);
        a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        d = $urandom;
    endtask

    // one clock: compare at negedge, advance model across the posedge
    task automatic step();
        bit era, erb, acc_a, acc_b;
        @(negedge clock);
        era = 0;
        erb = 0;
        if (e >= 33) begin
            if (pa_v && !pb_v) era = 1;
            else if (pb_v && !pa_v) erb = 1;
            else if (pa_v && pb_v) begin
                if (m_last) era = 1;
                else erb = 1;
            end
        end
        chk("req_a_ready", 32'(req_a_ready), 32'(era));
        chk("req_b_ready", 32'(req_b_ready), 32'(erb));
        chk("init_done", 32'(init_done), 32'(e >= 33));
        chk("rf_WriteEnable", 32'(rf_WriteEnable), 32'(ewe));
        chk("rf_write_address", 32'(rf_write_address), 32'(ea));
        chk("rf_write_data", rf_write_data, ed);
        acc_a = era && pa_v;
        acc_b = erb && pb_v;
        @(posedge clock);
        e++;
        if (e <= 32) begin
            ea = 5'(e - 1);
            ed = 32'(e - 1);
            ewe = 1;
        end else if (acc_a) begin
            ea = pa_addr;
            ed = pa_data;
            ewe = (pa_addr != 0);
            m_last = 0;
        end else if (acc_b) begin
            ea = pb_addr;
            ed = pb_data;
            ewe = (pb_addr != 0);
            m_last = 1;
        end else begin
            ewe = 0;
        end
        #2;
        if (acc_a) pa_v = 0;
        if (acc_b) pb_v = 0;
        if (rand_mode) begin
            if (!pa_v && $urandom_range(0, 1) == 1) begin
                new_req(pa_addr, pa_data);
                pa_v = 1;
            end
            if (!pb_v && $urandom_range(0, 1) == 1) begin
                new_req(pb_addr, pb_data);
                pb_v = 1;
            end
        end
        apply();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pa_v || pb_v) && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (pa_v || pb_v) begin
            errors++;
            $display("FAIL drain: requests still pending after %0d cycles", n);
        end
    endtask

    initial begin
        int hits;
        model_reset();
        pa_v = 1; pa_addr = 5'd3; pa_data = 32'h33;
        pb_v = 1; pb_addr = 5'd7; pb_data = 32'h77;
        apply();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_we", 32'(rf_WriteEnable), 32'd0);
        chk("reset_init_done", 32'(init_done), 32'd0);
        chk("reset_ready_a", 32'(req_a_ready), 32'd0);
        #1 reset = 1;

        // init sequence with both valids held high
        for (int i = 1; i <= 33; i++) begin
            step();
            if (e == 1) begin
                chk("init_first_addr", 32'(rf_write_address), 32'd0);
                chk("init_first_we", 32'(rf_WriteEnable), 32'd1);
            end
            if (e == 5) chk("init_ready_b", 32'(req_b_ready), 32'd0);
            if (e == 32) begin
                chk("init_last_addr", 32'(rf_write_address), 32'd31);
                chk("init_last_data", rf_write_data, 32'd31);
                chk("init_done_early", 32'(init_done), 32'd0);
            end
            if (e == 33) begin
                chk("init_done_33", 32'(init_done), 32'd1);
                chk("init_we_33", 32'(rf_WriteEnable), 32'd0);
            end
        end

        // continuous contention: A,B,A,B
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alt_addr", 32'(rf_write_address), (i % 2 == 0) ? 32'd3 : 32'd7);
            chk("alt_we", 32'(rf_WriteEnable), 32'd1);
            if (!pa_v) begin pa_v = 1; pa_addr = 5'd3; pa_data = 32'h33; end
            if (!pb_v) begin pb_v = 1; pb_addr = 5'd7; pb_data = 32'h77; end
            apply();
        end
        drain();

        // A only
        pa_v = 1; pa_addr = 5'd5; pa_data = 32'hDEADBEEF;
        apply();
        #1 chk("a_only_ready", 32'(req_a_ready), 32'd1);
        step();
        chk("a_only_addr", 32'(rf_write_address), 32'd5);
        chk("a_only_data", rf_write_data, 32'hDEADBEEF);
        chk("a_only_we", 32'(rf_WriteEnable), 32'd1);

        // B to register 0
        pb_v = 1; pb_addr = 5'd0; pb_data = 32'h1234;
        apply();
        #1 chk("zero_ready_b", 32'(req_b_ready), 32'd1);
        step();
        chk("zero_we", 32'(rf_WriteEnable), 32'd0);
        chk("zero_accepted", 32'(pb_v), 32'd0);

        // hold: A granted last, so B wins the tie and A waits
        pa_v = 1; pa_addr = 5'd9; pa_data = 32'hA9;
        apply();
        step();
        pa_v = 1; pa_addr = 5'd12; pa_data = 32'hAAAA0012;
        pb_v = 1; pb_addr = 5'd13; pb_data = 32'hBBBB0013;
        apply();
        #1 chk("hold_ready_a", 32'(req_a_ready), 32'd0);
        chk("hold_ready_b", 32'(req_b_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) chk("hold_b_first", 32'(rf_write_address), 32'd13);
            if (rf_WriteEnable && rf_write_address == 5'd12 &&
                rf_write_data == 32'hAAAA0012) hits++;
        end
        chk("hold_a_once", 32'(hits), 32'd1);

        // random traffic
        rand_mode = 1;
        repeat (400) step();
        rand_mode = 0;
        drain();

        // reset part-way through init
        #1 reset = 0;
        @(posedge clock);
        #2 reset = 1;
        model_reset();
        repeat (10) step();
        reset = 0;
        #1;
        chk("midreset_addr", 32'(rf_write_address), 32'd0);
        chk("midreset_data", rf_write_data, 32'd0);
        chk("midreset_we", 32'(rf_WriteEnable), 32'd0);
        chk("midreset_done", 32'(init_done), 32'd0);
        model_reset();
        @(posedge clock);
        #2 reset = 1;
        step();
        chk("restart_addr", 32'(rf_write_address), 32'd0);
        chk("restart_we", 32'(rf_WriteEnable), 32'd1);
        repeat (32) step();

        rand_mode = 1;
        repeat (200) step();
        rand_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
